// File: rtl/dot_product_accum_if.sv
// Operand/result stream bundle for dot_product_accum: the valid/ready input pair
// stream, the valid/ready result port, plus the clear/busy side controls.
interface dot_product_if #(
    parameter int BIT_WIDTH = 16
);
    logic                        clear;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [BIT_WIDTH-1:0] in_a;
    logic signed [BIT_WIDTH-1:0] in_b;
    logic signed [BIT_WIDTH-1:0] in_bias;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [BIT_WIDTH-1:0] out_data;
    logic                        busy;

    modport master (
        output clear, in_valid, in_a, in_b, in_bias, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  clear, in_valid, in_a, in_b, in_bias, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/dot_product_accum.sv
// Sequential dot-product accumulator: folds VEC_LEN (a, b) pairs into a bias-seeded sum.
// Define DOT_PRODUCT_SATURATE_EN for per-beat saturating arithmetic; wraps otherwise.
module dot_product_accum #(
    parameter int BIT_WIDTH = 16,
    parameter int VEC_LEN   = 16,
    parameter int CNT_WIDTH = $clog2(VEC_LEN + 1)
) (
    input  logic         clk,
    input  logic         rst,
    dot_product_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);

    state_t                      state_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic signed [BIT_WIDTH-1:0] acc_q;
    logic signed [BIT_WIDTH-1:0] acc_d;
    logic signed [BIT_WIDTH-1:0] seed;
    logic                        accept;

    // The first beat of a vector reseeds from the bias; later beats chain on acc.
    assign seed = (cnt_q == '0) ? bus.in_bias : acc_q;

`ifdef DOT_PRODUCT_SATURATE_EN
    localparam logic signed [2*BIT_WIDTH:0] SAT_MAX =
        {{(BIT_WIDTH + 2){1'b0}}, {(BIT_WIDTH - 1){1'b1}}};
    localparam logic signed [2*BIT_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic [2*BIT_WIDTH-1:0]      prod;
    logic signed [2*BIT_WIDTH:0] sum_full;

    assign prod = {{BIT_WIDTH{bus.in_a[BIT_WIDTH-1]}}, bus.in_a}
                * {{BIT_WIDTH{bus.in_b[BIT_WIDTH-1]}}, bus.in_b};
    assign sum_full = {prod[2*BIT_WIDTH-1], prod}
                    + {{(BIT_WIDTH + 1){seed[BIT_WIDTH-1]}}, seed};

    always_comb begin
        if (sum_full > SAT_MAX) begin
            acc_d = {1'b0, {(BIT_WIDTH - 1){1'b1}}};
        end else if (sum_full < SAT_MIN) begin
            acc_d = {1'b1, {(BIT_WIDTH - 1){1'b0}}};
        end else begin
            acc_d = sum_full[BIT_WIDTH-1:0];
        end
    end
`else
    // Low bits of a product do not depend on operand signedness, so this is the
    // truncated signed multiply-add.
    assign acc_d = bus.in_a * bus.in_b + seed;
`endif

    assign bus.in_ready  = (state_q == ACCUM) & ~bus.clear;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.busy      = (cnt_q != '0) | (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (bus.clear) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_accum.sv
// Self-checking bench for dot_product_accum: scoreboard queues filled by the stimulus,
// drained by monitors; honours DOT_PRODUCT_SATURATE_EN in its reference model.
module tb_dot_product_accum;
    localparam int BW = 16;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_if #(.BIT_WIDTH(BW)) ifc ();
    dot_product_if #(.BIT_WIDTH(BW)) ifc1 ();

    dot_product_accum #(.BIT_WIDTH(BW), .VEC_LEN(VL)) dut (.clk(clk), .rst(rst), .bus(ifc));
    dot_product_accum #(.BIT_WIDTH(BW), .VEC_LEN(1))  dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    int checks   = 0;
    int failures = 0;

    logic signed [BW-1:0] q4[$];
    logic signed [BW-1:0] q1[$];
    logic signed [BW-1:0] va[VL];
    logic signed [BW-1:0] vb[VL];

    bit rand_mode = 1'b0;
    bit rnd_bit   = 1'b0;
    bit or_fixed  = 1'b1;

    assign ifc.out_ready  = rand_mode ? rnd_bit : or_fixed;
    assign ifc1.out_ready = 1'b1;

    // Reference: the dot product of the vector plus bias, reduced to BW bits at the end
    // (wrap) or clamped after every term (saturate).
    function automatic logic signed [BW-1:0] model_dot(input longint bias, input int n);
        longint s = bias;
        for (int i = 0; i < n; i++) begin
            s = s + longint'(va[i]) * longint'(vb[i]);
`ifdef DOT_PRODUCT_SATURATE_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`endif
        end
        return s[BW-1:0];
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    task automatic send_beat(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b,
                             input logic signed [BW-1:0] bias, input bit last,
                             input logic signed [BW-1:0] exp, output int waits);
        bit ok = 1'b0;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_bias  = bias;
        ifc.in_valid = 1'b1;
        waits = 0;
        while (!ok) begin
            @(negedge clk);
            if (ifc.in_ready) ok = 1'b1;
            else begin
                waits++;
                if (waits > 200) begin
                    timeout_fail("in_accept");
                    break;
                end
            end
        end
        if (ok && last) q4.push_back(exp);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        $display("beat a=%0d b=%0d bias=%0d waits=%0d last=%0d", a, b, bias, waits, last);
    endtask

    task automatic run_vec(input logic signed [BW-1:0] bias, input bit use_lit, input int lit,
                           input int max_gap, output int first_waits);
        logic signed [BW-1:0] exp;
        int w;
        exp = use_lit ? BW'(lit) : model_dot(bias, VL);
        first_waits = 0;
        for (int i = 0; i < VL; i++) begin
            if (i > 0) begin
                int gaps = $urandom_range(0, max_gap);
                repeat (gaps) begin
                    @(negedge clk);
                    check("busy_mid_vector", ifc.busy, 1);
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(va[i], vb[i], bias, i == VL - 1, exp, w);
            if (i == 0) first_waits = w;
        end
    endtask

    task automatic send1(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b,
                         input logic signed [BW-1:0] bias, input logic signed [BW-1:0] exp);
        int waits = 0;
        bit ok = 1'b0;
        ifc1.in_a     = a;
        ifc1.in_b     = b;
        ifc1.in_bias  = bias;
        ifc1.in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (ifc1.in_ready) ok = 1'b1;
            else if (++waits > 50) begin
                timeout_fail("in_accept_len1");
                break;
            end
        end
        if (ok) q1.push_back(exp);
        @(posedge clk);
        #1;
        ifc1.in_valid = 1'b0;
    endtask

    task automatic monitor4();
        logic signed [BW-1:0] held = '0;
        bit stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) stalled = 1'b0;
            else begin
                if (ifc.out_valid && stalled) check("stall_hold", ifc.out_data, held);
                if (ifc.out_valid && ifc.out_ready) begin
                    stalled = 1'b0;
                    if (q4.size() == 0) check("unexpected_result", ifc.out_data, 64'sd99999);
                    else begin
                        logic signed [BW-1:0] e = q4.pop_front();
                        check("result", ifc.out_data, e);
                        $display("result got=%0d exp=%0d", ifc.out_data, e);
                    end
                end else if (ifc.out_valid) begin
                    stalled = 1'b1;
                    held    = ifc.out_data;
                end else stalled = 1'b0;
            end
        end
    endtask

    task automatic monitor1();
        forever begin
            @(negedge clk);
            if (!rst && ifc1.out_valid) begin
                if (q1.size() == 0) check("unexpected_result_len1", ifc1.out_data, 64'sd99999);
                else begin
                    logic signed [BW-1:0] e = q1.pop_front();
                    check("result_len1", ifc1.out_data, e);
                    $display("result_len1 got=%0d exp=%0d", ifc1.out_data, e);
                end
            end
        end
    endtask

    task automatic rand_drv();
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic load_basic();
        va[0] = 1;  vb[0] = 2;
        va[1] = 3;  vb[1] = 4;
        va[2] = -5; vb[2] = 6;
        va[3] = 7;  vb[3] = -1;
    endtask

    task automatic load_ones();
        for (int i = 0; i < VL; i++) begin
            va[i] = 1;
            vb[i] = 1;
        end
    endtask

    initial begin
        int w;
        int e1, e2;
        ifc.clear = 1'b0;  ifc.in_valid = 1'b0;
        ifc.in_a = '0;     ifc.in_b = '0;  ifc.in_bias = '0;
        ifc1.clear = 1'b0; ifc1.in_valid = 1'b0;
        ifc1.in_a = '0;    ifc1.in_b = '0; ifc1.in_bias = '0;
        fork
            monitor4();
            monitor1();
            rand_drv();
        join_none

        // Reset state
        #2;
        check("rst_in_ready", ifc.in_ready, 1);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_data", ifc.out_data, 0);
        check("rst_busy", ifc.busy, 0);
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic vector with latency and single-cycle in_ready drop
        load_basic();
        run_vec(16'sd10, 1'b1, -13, 0, w);
        @(negedge clk);
        check("basic_out_valid_rise", ifc.out_valid, 1);
        check("basic_in_ready_low", ifc.in_ready, 0);
        check("basic_busy_done", ifc.busy, 1);
        @(negedge clk);
        check("basic_in_ready_back", ifc.in_ready, 1);
        check("basic_out_valid_fall", ifc.out_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure for 5 cycles, then next vector offered during the handshake cycle
        or_fixed = 1'b0;
        run_vec(16'sd10, 1'b1, -13, 0, w);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", ifc.out_valid, 1);
            check("bp_in_ready", ifc.in_ready, 0);
            check("bp_out_data", ifc.out_data, -13);
        end
        @(posedge clk);
        #1;
        or_fixed = 1'b1;
        load_ones();
        run_vec(16'sd0, 1'b1, 4, 0, w);
        check("bp_next_first_waits", w, 1);
        repeat (2) @(posedge clk);
        #1;

        // Clear after beat 2 with in_valid high
        load_basic();
        send_beat(va[0], vb[0], 16'sd10, 1'b0, '0, w);
        send_beat(va[1], vb[1], 16'sd10, 1'b0, '0, w);
        ifc.in_a = 16'sd9; ifc.in_b = 16'sd9; ifc.in_valid = 1'b1; ifc.clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", ifc.in_ready, 0);
        @(posedge clk);
        #1;
        ifc.clear = 1'b0; ifc.in_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", ifc.busy, 0);
        @(posedge clk);
        #1;
        load_ones();
        run_vec(16'sd0, 1'b1, 4, 0, w);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-vector
        load_basic();
        send_beat(va[0], vb[0], 16'sd10, 1'b0, '0, w);
        send_beat(va[1], vb[1], 16'sd10, 1'b0, '0, w);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", ifc.out_valid, 0);
        check("arst_out_data", ifc.out_data, 0);
        check("arst_busy", ifc.busy, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(16'sd10, 1'b1, -13, 0, w);
        repeat (2) @(posedge clk);
        #1;

        // Bubbles in the basic vector
        repeat (3) run_vec(16'sd10, 1'b1, -13, 3, w);
        repeat (2) @(posedge clk);
        #1;

        // Length-1 instance: wrap / saturate corners
`ifdef DOT_PRODUCT_SATURATE_EN
        e1 = 32767;  e2 = -32768;
`else
        e1 = -32768; e2 = 0;
`endif
        send1(16'sd1, 16'sd1, 16'sd32767, BW'(e1));
        send1(-16'sd32768, 16'sd2, 16'sd0, BW'(e2));
        for (int k = 0; k < 10; k++) begin
            logic signed [BW-1:0] bias;
            va[0] = BW'($urandom);
            vb[0] = BW'($urandom);
            bias  = BW'($urandom);
            send1(va[0], vb[0], bias, model_dot(longint'(bias), 1));
        end

        // Random vectors with random output backpressure
        rand_mode = 1'b1;
        for (int k = 0; k < 15; k++) begin
            logic signed [BW-1:0] bias;
            for (int i = 0; i < VL; i++) begin
                va[i] = (k % 2 == 0) ? BW'($urandom) : BW'($urandom_range(0, 200)) - 16'sd100;
                vb[i] = (k % 2 == 0) ? BW'($urandom) : BW'($urandom_range(0, 200)) - 16'sd100;
            end
            bias = BW'($urandom);
            run_vec(bias, 1'b0, 0, 2, w);
        end
        rand_mode = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
